pipe_controller: RTL and testbench
==================================

PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 SHALL have parameter IO_PREFIX, default 24'hFFFFFC; the MMIO region is addresses whose bits [31:8] equal it.
REQ-002 SHALL have parameter MEXT, default 1; 1 enables multi-cycle divide stall support.
REQ-003 SHALL have parameter DIV_LAT, default 8, legal range 2..32; the divide occupies EX for exactly DIV_LAT cycles.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 id_inst  in  32  instruction in ID.
REQ-008 id_valid  in  1  id_inst is a real instruction.
REQ-009 ex_alu_result  in  32  ALU result of the EX instruction.
REQ-010 ex_branch_taken  in  1  EX branch compare true.
REQ-011 id_stall  out  1  hold PC and IF/ID register.
REQ-012 if_flush  out  1  squash IF/ID and redirect PC.
REQ-013 ex_valid, ex_branch, ex_jump, ex_jalr, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite  out  1 each  registered EX control bits.
REQ-014 ex_utype  out  2  {LUI, AUIPC}; ex_aluop  out  2; ex_rd  out  5.
REQ-015 ex_div_busy  out  1  divide in progress.
REQ-016 mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_ioread, mem_iowrite  out  1 each; mem_rd  out  5  registered MEM controls.

Function
REQ-017 Decode SHALL use: Branch = B; Jump = JAL; Jalr = JALR; ALUOp[1] = not (L, S or B); ALUOp[0] = not (L, S or R); ALUSrc = I, L, S, LUI or AUIPC; MemRead = MemtoReg = L; MemWrite = S; RegWrite = R, I, L, LUI, AUIPC, JAL or JALR.
REQ-018 An unrecognised opcode, or id_valid = 0, SHALL decode to all-zero controls.
REQ-019 ID to EX latency SHALL be 1 cycle; EX to MEM latency SHALL be 1 cycle.
REQ-020 rs1 SHALL count as used for R, I, L, S, B and JALR; rs2 for R, S and B.
REQ-021 Load-use SHALL be detected when ex_valid & ex_memread & ex_rd != 0 & ex_rd matches a used rs1 or rs2 of a valid ID instruction.
REQ-022 On load-use: id_stall = 1; a bubble (all EX controls 0) is loaded into EX next cycle; stall length is 1 cycle.
REQ-023 if_flush SHALL equal ex_valid & (ex_jump | ex_jalr | (ex_branch & ex_branch_taken)), combinationally.
REQ-024 On flush, EX SHALL load a bubble next cycle.
REQ-025 Flush SHALL take priority over load-use stall (id_stall = 0 when if_flush = 1).
REQ-026 With MEXT = 1, an ID instruction that is R, funct7 = 0000001 and funct3[2] = 1 SHALL, on entry to EX, load the divide counter with DIV_LAT-1.
REQ-027 While the counter != 0: ex_div_busy = 1; id_stall = 1; the EX register holds; MEM receives a bubble; counter decrements.
REQ-028 The divide SHALL advance to MEM in the cycle after the counter reaches 0.
REQ-029 With MEXT = 0, divide encodings SHALL be treated as an ordinary R instruction with no stall.
REQ-030 mem_ioread SHALL be registered ex_memread & (ex_alu_result[31:8] == IO_PREFIX); mem_iowrite likewise using ex_memwrite.
REQ-031 A bubble SHALL propagate with all MEM controls 0.

Reset
REQ-032 While rst = 1 at a clock edge, every registered output and the divide counter SHALL become 0; id_stall and if_flush SHALL read 0 the following cycle.
REQ-033 Reset asserted mid-divide SHALL abort it: ex_div_busy = 0 the next cycle; no divide reaches MEM.
REQ-034 The first ID instruction after reset deasserts SHALL reach EX one cycle later.

Verification
REQ-035 lw x5,0(x1) followed by add x6,x5,x2 -> id_stall = 1 for exactly 1 cycle; one bubble in EX; add reaches EX 2 cycles after the lw.
REQ-036 beq with ex_branch_taken = 1 -> if_flush = 1 in that cycle; next-cycle EX controls all 0.
REQ-037 sw with ex_alu_result = 0xFFFFFC10 -> mem_iowrite = 1, mem_memwrite = 1; with 0x00000010 -> mem_iowrite = 0.
REQ-038 div x3,x4,x5 with DIV_LAT = 8 -> ex_div_busy high for 7 cycles; id_stall high for the same 7 cycles; div in MEM on the 9th cycle after issue.
REQ-039 rst pulsed for 1 cycle during a divide -> all outputs 0 next cycle; a subsequent addi flows through with no stall.
REQ-040 lui x7,0x12345 -> ex_utype = 2'b10, ex_alusrc = 1, ex_regwrite = 1, ex_aluop = 2'b11.

Source files
------------

// File: rtl/pipe_controller.sv
// Pipeline control for a 5-stage RV32 core: decode, ID/EX and EX/MEM control registers,
// load-use and multi-cycle divide stalls, control-transfer flush and MMIO tagging.
module pipe_controller #(
   parameter logic [23:0] IO_PREFIX = 24'hFFFFFC,
   parameter int          MEXT      = 1,
   parameter int          DIV_LAT   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] id_inst,
   input  logic        id_valid,
   input  logic [31:0] ex_alu_result,
   input  logic        ex_branch_taken,
   output logic        id_stall,
   output logic        if_flush,
   output logic        ex_valid,
   output logic        ex_branch,
   output logic        ex_jump,
   output logic        ex_jalr,
   output logic        ex_alusrc,
   output logic        ex_memread,
   output logic        ex_memwrite,
   output logic        ex_memtoreg,
   output logic        ex_regwrite,
   output logic [1:0]  ex_utype,
   output logic [1:0]  ex_aluop,
   output logic [4:0]  ex_rd,
   output logic        ex_div_busy,
   output logic        mem_valid,
   output logic        mem_memread,
   output logic        mem_memwrite,
   output logic        mem_memtoreg,
   output logic        mem_regwrite,
   output logic        mem_ioread,
   output logic        mem_iowrite,
   output logic [4:0]  mem_rd
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam int            CW       = $clog2(DIV_LAT);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

   typedef struct packed {
      logic       valid;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic       alusrc;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic [1:0] utype;
      logic [1:0] aluop;
      logic [4:0] rd;
   } ex_ctrl_t;

   typedef struct packed {
      logic       valid;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       ioread;
      logic       iowrite;
      logic [4:0] rd;
   } mem_ctrl_t;

   ex_ctrl_t      ex_reg, ex_next;
   mem_ctrl_t     mem_reg, mem_next;
   ex_ctrl_t      dec;
   logic [CW-1:0] div_cnt_reg, div_cnt_next;

   logic [6:0] opcode;
   logic       is_r, is_i, is_l, is_s, is_b, is_jal, is_jalr, is_lui, is_auipc, known;
   logic       rs1_used, rs2_used, dec_div;
   logic       div_busy, load_use, flush, io_hit;
   logic       unused_bits;

   assign unused_bits = ^{id_inst[13:12], ex_alu_result[7:0]};

   assign opcode   = id_inst[6:0];
   assign is_r     = (opcode == OP_R);
   assign is_i     = (opcode == OP_I);
   assign is_l     = (opcode == OP_L);
   assign is_s     = (opcode == OP_S);
   assign is_b     = (opcode == OP_B);
   assign is_jal   = (opcode == OP_JAL);
   assign is_jalr  = (opcode == OP_JALR);
   assign is_lui   = (opcode == OP_LUI);
   assign is_auipc = (opcode == OP_AUIPC);
   assign known    = is_r | is_i | is_l | is_s | is_b | is_jal | is_jalr | is_lui | is_auipc;

   // Unknown opcodes and empty slots decode to a bubble; rd is only kept when it is written.
   always_comb begin
      dec      = '0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      dec_div  = 1'b0;
      if (id_valid && known) begin
         dec.valid    = 1'b1;
         dec.branch   = is_b;
         dec.jump     = is_jal;
         dec.jalr     = is_jalr;
         dec.alusrc   = is_i | is_l | is_s | is_lui | is_auipc;
         dec.memread  = is_l;
         dec.memwrite = is_s;
         dec.memtoreg = is_l;
         dec.regwrite = is_r | is_i | is_l | is_lui | is_auipc | is_jal | is_jalr;
         dec.utype    = {is_lui, is_auipc};
         dec.aluop    = {~(is_l | is_s | is_b), ~(is_l | is_s | is_r)};
         dec.rd       = dec.regwrite ? id_inst[11:7] : 5'd0;
         rs1_used     = is_r | is_i | is_l | is_s | is_b | is_jalr;
         rs2_used     = is_r | is_s | is_b;
         dec_div      = (MEXT != 0) && is_r && (id_inst[31:25] == 7'b0000001) && id_inst[14];
      end
   end

   assign div_busy = (div_cnt_reg != '0);
   assign load_use = ex_reg.valid && ex_reg.memread && (ex_reg.rd != 5'd0) &&
                     ((rs1_used && (id_inst[19:15] == ex_reg.rd)) ||
                      (rs2_used && (id_inst[24:20] == ex_reg.rd)));
   assign flush    = ex_reg.valid && (ex_reg.jump || ex_reg.jalr || (ex_reg.branch && ex_branch_taken));
   assign if_flush = flush;
   assign id_stall = !flush && (load_use || div_busy);
   assign io_hit   = (ex_alu_result[31:8] == IO_PREFIX);

   // A running divide freezes EX and feeds bubbles to MEM until its counter drains.
   always_comb begin
      ex_next      = dec;
      div_cnt_next = '0;
      if (div_busy) begin
         ex_next      = ex_reg;
         div_cnt_next = div_cnt_reg - CW'(1);
      end else if (flush || load_use) begin
         ex_next = '0;
      end else if (dec_div) begin
         div_cnt_next = DIV_LOAD;
      end
   end

   always_comb begin
      mem_next = '0;
      if (!div_busy) begin
         mem_next.valid    = ex_reg.valid;
         mem_next.memread  = ex_reg.memread;
         mem_next.memwrite = ex_reg.memwrite;
         mem_next.memtoreg = ex_reg.memtoreg;
         mem_next.regwrite = ex_reg.regwrite;
         mem_next.ioread   = ex_reg.memread && io_hit;
         mem_next.iowrite  = ex_reg.memwrite && io_hit;
         mem_next.rd       = ex_reg.rd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_reg      <= '0;
         mem_reg     <= '0;
         div_cnt_reg <= '0;
      end else begin
         ex_reg      <= ex_next;
         mem_reg     <= mem_next;
         div_cnt_reg <= div_cnt_next;
      end
   end

   assign ex_valid     = ex_reg.valid;
   assign ex_branch    = ex_reg.branch;
   assign ex_jump      = ex_reg.jump;
   assign ex_jalr      = ex_reg.jalr;
   assign ex_alusrc    = ex_reg.alusrc;
   assign ex_memread   = ex_reg.memread;
   assign ex_memwrite  = ex_reg.memwrite;
   assign ex_memtoreg  = ex_reg.memtoreg;
   assign ex_regwrite  = ex_reg.regwrite;
   assign ex_utype     = ex_reg.utype;
   assign ex_aluop     = ex_reg.aluop;
   assign ex_rd        = ex_reg.rd;
   assign ex_div_busy  = div_busy;

   assign mem_valid    = mem_reg.valid;
   assign mem_memread  = mem_reg.memread;
   assign mem_memwrite = mem_reg.memwrite;
   assign mem_memtoreg = mem_reg.memtoreg;
   assign mem_regwrite = mem_reg.regwrite;
   assign mem_ioread   = mem_reg.ioread;
   assign mem_iowrite  = mem_reg.iowrite;
   assign mem_rd       = mem_reg.rd;

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: MEM-stage results are checked against a scoreboard
// of expected control records pushed as each instruction is issued.
module tb_pipe_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] id_inst;
   logic        id_valid;
   logic [31:0] ex_alu_result;
   logic        ex_branch_taken;
   logic        id_stall, if_flush;
   logic        ex_valid, ex_branch, ex_jump, ex_jalr, ex_alusrc;
   logic        ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
   logic [1:0]  ex_utype, ex_aluop;
   logic [4:0]  ex_rd;
   logic        ex_div_busy;
   logic        mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
   logic        mem_ioread, mem_iowrite;
   logic [4:0]  mem_rd;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [10:0] sb[$];

   localparam logic [31:0] LW_X5    = 32'h0000A283;   // lw   x5,0(x1)
   localparam logic [31:0] ADD_X6   = 32'h00228333;   // add  x6,x5,x2
   localparam logic [31:0] BEQ      = 32'h00208463;   // beq  x1,x2,8
   localparam logic [31:0] SW       = 32'h0020A023;   // sw   x2,0(x1)
   localparam logic [31:0] DIV_X3   = 32'h025241B3;   // div  x3,x4,x5
   localparam logic [31:0] LUI_X7   = 32'h123453B7;   // lui  x7,0x12345
   localparam logic [31:0] ADDI_X8  = 32'h00100413;   // addi x8,x0,1
   localparam logic [31:0] JAL_X1   = 32'h010000EF;   // jal  x1,16
   localparam logic [31:0] BAD_OP   = 32'hFFFFFFFF;

   pipe_controller dut (
      .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
      .ex_alu_result(ex_alu_result), .ex_branch_taken(ex_branch_taken),
      .id_stall(id_stall), .if_flush(if_flush),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
      .ex_alusrc(ex_alusrc), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_utype(ex_utype),
      .ex_aluop(ex_aluop), .ex_rd(ex_rd), .ex_div_busy(ex_div_busy),
      .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
      .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_ioread(mem_ioread),
      .mem_iowrite(mem_iowrite), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Record layout: {rd, memread, memwrite, memtoreg, regwrite, ioread, iowrite}
   function automatic logic [10:0] rec(input logic [4:0] rd, input logic mr, input logic mw,
                                       input logic mt, input logic rw, input logic ir, input logic iw);
      return {rd, mr, mw, mt, rw, ir, iw};
   endfunction

   task automatic tick();
      logic [10:0] got, exp;
      @(posedge clk);
      #1;
      if (mem_valid) begin
         got = {mem_rd, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite, mem_ioread, mem_iowrite};
         if (sb.size() == 0) begin
            chk("mem_spurious", {31'b0, mem_valid}, 32'd0);
         end else begin
            exp = sb.pop_front();
            chk("mem_out", {21'b0, got}, {21'b0, exp});
            $display("[TB] MEM rd=%0d ctl=%b", mem_rd, got[5:0]);
         end
      end
   endtask

   task automatic drive(input logic [31:0] inst, input logic v);
      id_inst  = inst;
      id_valid = v;
      #1;
   endtask

   initial begin
      rst = 1'b1; ex_alu_result = 32'h0; ex_branch_taken = 1'b0;
      drive(JAL_X1, 1'b1);
      tick(); tick();
      chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("rst_flush", {31'b0, if_flush}, 32'd0);
      chk("rst_stall", {31'b0, id_stall}, 32'd0);
      chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("rst_busy", {31'b0, ex_div_busy}, 32'd0);
      rst = 1'b0;
      drive(32'h0, 1'b0);
      tick();

      // Load-use: one stall cycle, one bubble, add in EX two cycles after the lw.
      drive(LW_X5, 1'b1);
      tick();
      chk("lw_ex_memread", {31'b0, ex_memread}, 32'd1);
      chk("lw_ex_rd", {27'b0, ex_rd}, 32'd5);
      sb.push_back(rec(5'd5, 1, 0, 1, 1, 0, 0));
      drive(ADD_X6, 1'b1);
      chk("lu_stall", {31'b0, id_stall}, 32'd1);
      tick();
      chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
      chk("lu_stall_end", {31'b0, id_stall}, 32'd0);
      sb.push_back(rec(5'd6, 0, 0, 0, 1, 0, 0));
      tick();
      chk("add_ex_rd", {27'b0, ex_rd}, 32'd6);
      chk("add_ex_aluop", {30'b0, ex_aluop}, 32'd2);
      drive(32'h0, 1'b0);
      tick();

      // Taken branch: flush in the same cycle, squashed follower becomes a bubble.
      drive(BEQ, 1'b1);
      tick();
      sb.push_back(rec(5'd0, 0, 0, 0, 0, 0, 0));
      chk("beq_aluop", {30'b0, ex_aluop}, 32'd1);
      drive(ADDI_X8, 1'b1);
      ex_branch_taken = 1'b1;
      #1;
      chk("beq_flush", {31'b0, if_flush}, 32'd1);
      chk("beq_no_stall", {31'b0, id_stall}, 32'd0);
      tick();
      ex_branch_taken = 1'b0;
      chk("flush_bubble", {16'b0, ex_valid, ex_regwrite, ex_branch, ex_alusrc, ex_aluop, ex_rd, ex_memread, ex_memwrite, ex_memtoreg, ex_jump}, 32'd0);
      drive(32'h0, 1'b0);
      tick();

      // Jump flushes unconditionally.
      drive(JAL_X1, 1'b1);
      tick();
      sb.push_back(rec(5'd1, 0, 0, 0, 1, 0, 0));
      drive(32'h0, 1'b0);
      chk("jal_flush", {31'b0, if_flush}, 32'd1);
      tick(); tick();

      // MMIO tagging on stores and loads.
      drive(SW, 1'b1);
      tick();
      ex_alu_result = 32'hFFFFFC10;
      sb.push_back(rec(5'd0, 0, 1, 0, 0, 0, 1));
      drive(SW, 1'b1);
      tick();
      chk("sw_io_iowrite", {31'b0, mem_iowrite}, 32'd1);
      chk("sw_io_memwrite", {31'b0, mem_memwrite}, 32'd1);
      ex_alu_result = 32'h00000010;
      sb.push_back(rec(5'd0, 0, 1, 0, 0, 0, 0));
      drive(LW_X5, 1'b1);
      tick();
      chk("sw_ram_iowrite", {31'b0, mem_iowrite}, 32'd0);
      ex_alu_result = 32'hFFFFFC00;
      sb.push_back(rec(5'd5, 1, 0, 1, 1, 1, 0));
      drive(32'h0, 1'b0);
      tick(); tick();
      ex_alu_result = 32'h0;

      // LUI controls, then unknown opcode and an invalid slot both become bubbles.
      drive(LUI_X7, 1'b1);
      tick();
      chk("lui_utype", {30'b0, ex_utype}, 32'd2);
      chk("lui_alusrc", {31'b0, ex_alusrc}, 32'd1);
      chk("lui_regwrite", {31'b0, ex_regwrite}, 32'd1);
      chk("lui_aluop", {30'b0, ex_aluop}, 32'd3);
      sb.push_back(rec(5'd7, 0, 0, 0, 1, 0, 0));
      drive(BAD_OP, 1'b1);
      tick();
      chk("badop_valid", {31'b0, ex_valid}, 32'd0);
      drive(LW_X5, 1'b0);
      tick();
      chk("invalid_memread", {31'b0, ex_memread}, 32'd0);
      tick();

      // Divide: busy and stall for DIV_LAT-1 cycles, MEM on the 9th cycle after issue.
      drive(DIV_X3, 1'b1);
      sb.push_back(rec(5'd3, 0, 0, 0, 1, 0, 0));
      tick();
      drive(ADDI_X8, 1'b1);
      for (int c = 1; c <= 7; c++) begin
         chk($sformatf("div_busy_c%0d", c), {31'b0, ex_div_busy}, 32'd1);
         chk($sformatf("div_stall_c%0d", c), {31'b0, id_stall}, 32'd1);
         chk($sformatf("div_mem_bubble_c%0d", c), {31'b0, mem_valid}, 32'd0);
         tick();
      end
      chk("div_busy_c8", {31'b0, ex_div_busy}, 32'd0);
      chk("div_stall_c8", {31'b0, id_stall}, 32'd0);
      chk("div_ex_rd_c8", {27'b0, ex_rd}, 32'd3);
      sb.push_back(rec(5'd8, 0, 0, 0, 1, 0, 0));
      tick();
      chk("div_in_mem_c9", {27'b0, mem_rd}, 32'd3);
      chk("addi_ex_rd", {27'b0, ex_rd}, 32'd8);
      drive(32'h0, 1'b0);
      tick(); tick();

      // Reset in the middle of a divide aborts it; the next addi flows with no stall.
      drive(DIV_X3, 1'b1);
      tick();
      drive(32'h0, 1'b0);
      tick();
      chk("abort_busy_before", {31'b0, ex_div_busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", {31'b0, ex_div_busy}, 32'd0);
      chk("abort_ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("abort_mem_valid", {31'b0, mem_valid}, 32'd0);
      drive(ADDI_X8, 1'b1);
      chk("abort_addi_stall", {31'b0, id_stall}, 32'd0);
      tick();
      chk("abort_addi_ex", {26'b0, ex_valid, ex_rd}, 32'h28);
      sb.push_back(rec(5'd8, 0, 0, 0, 1, 0, 0));
      drive(32'h0, 1'b0);
      for (int c = 0; c < 12; c++) tick();

      chk("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
